alu_pipe_seg: RTL and testbench

Parametrised, handshaked successor to the two-register ALU display path. An N-bit ALU sits inside an elastic pipeline of configurable depth with valid/ready flow control. It produces a result, NZCV flags, a completed-operation counter and optional hex 7-segment encodings of the result. It sits between the board input/debounce logic and the display drivers.

---
 rtl/alu_pipe_pkg.sv | 35 +++
 rtl/alu_core.sv | 95 +++++++++
 rtl/alu_pipe_seg.sv | 93 +++++++++
 tb/tb_alu_pipe_seg.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the pipelined ALU: op codes, flag bit positions and
// the active-low hex glyph table used by the optional result display.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_MUL = 4'd2,
    ALU_DIV = 4'd3,
    ALU_MOD = 4'd4,
    ALU_AND = 4'd5,
    ALU_OR  = 4'd6,
    ALU_XOR = 4'd7,
    ALU_SHL = 4'd8,
    ALU_SHR = 4'd9
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Glyphs are {g,f,e,d,c,b,a}, active-low; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_GLYPHS[nib];
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational N-bit ALU: result plus {N,Z,C,V} flags for one op code.
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   op,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;

  alu_op_e       op_e;
  logic [SW-1:0] sh;
  logic [N:0]    sum;
  logic [N-1:0]  diff;
  logic [2*N-1:0] prod;
  logic [N:0]    shl_w;
  logic [N:0]    shr_w;
  logic [N-1:0]  r;
  logic          c;
  logic          v;

  assign op_e  = alu_op_e'(op);
  assign sh    = b[SW-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = a - b;
  assign prod  = {{N{1'b0}}, a} * {{N{1'b0}}, b};
  // One guard bit on the exit side captures the last bit shifted out.
  assign shl_w = {1'b0, a} << sh;
  assign shr_w = {a, 1'b0} >> sh;

  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (op_e)
      ALU_ADD: begin
        r = sum[N-1:0];
        c = sum[N];
        v = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        r = diff;
        c = (a < b);
        v = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      ALU_MUL: begin
        r = prod[N-1:0];
        c = |prod[2*N-1:N];
      end
      ALU_DIV: begin
        if (b == '0) begin
          r = '1;
          v = 1'b1;
        end else begin
          r = a / b;
        end
      end
      ALU_MOD: begin
        if (b == '0) begin
          r = '1;
          v = 1'b1;
        end else begin
          r = a % b;
        end
      end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SHL: begin
        r = shl_w[N-1:0];
        c = shl_w[N];
      end
      ALU_SHR: begin
        r = shr_w[N:1];
        c = shr_w[0];
      end
      default: v = 1'b1;
    endcase
  end

  always_comb begin
    result         = r;
    flags          = '0;
    flags[FLAG_N]  = r[N-1];
    flags[FLAG_Z]  = (r == '0);
    flags[FLAG_C]  = c;
    flags[FLAG_V]  = v;
  end

endmodule

// File: rtl/alu_pipe_seg.sv
// Elastic ALU pipeline with valid/ready handshake, op counter and hex display.
// Define ALU_SEG_DISPLAY_EN to build the 7-segment decoders; otherwise blank.
module alu_pipe_seg
  import alu_pipe_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int DEPTH = 2,
  parameter  int CNT_W = 8,
  localparam int D     = (N + 3) / 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a_num,
  input  logic [N-1:0]     b_num,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     result,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] op_count,
  output logic [7*D-1:0]   seg_result
);

  logic             adv;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [3:0]       op_q;
  logic [DEPTH-1:0] vld_q;
  logic [N-1:0]     res_q [1:DEPTH-1];
  logic [3:0]       flg_q [1:DEPTH-1];
  logic [N-1:0]     alu_res;
  logic [3:0]       alu_flg;

  alu_core #(.N(N)) u_alu_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_res),
    .flags  (alu_flg)
  );

  // One global enable: every stage moves together or the whole pipe freezes.
  assign adv       = !vld_q[DEPTH-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[DEPTH-1];
  assign result    = res_q[DEPTH-1];
  assign flags     = flg_q[DEPTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      vld_q    <= '0;
      op_count <= '0;
      for (int i = 1; i < DEPTH; i++) begin
        res_q[i] <= '0;
        flg_q[i] <= '0;
      end
    end else begin
      if (adv) begin
        vld_q <= {vld_q[DEPTH-2:0], in_valid};
        if (in_valid) begin
          a_q  <= a_num;
          b_q  <= b_num;
          op_q <= op;
        end
        res_q[1] <= alu_res;
        flg_q[1] <= alu_flg;
        for (int i = 2; i < DEPTH; i++) begin
          res_q[i] <= res_q[i-1];
          flg_q[i] <= flg_q[i-1];
        end
      end
      if (out_valid && out_ready) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

`ifdef ALU_SEG_DISPLAY_EN
  logic [4*D-1:0] res_ext;
  assign res_ext = (4*D)'(result);
  for (genvar d = 0; d < D; d++) begin : g_digit
    assign seg_result[7*d +: 7] = hex_to_seg(res_ext[4*d +: 4]);
  end
`else
  assign seg_result = {D{SEG_BLANK}};
`endif

endmodule

// File: tb/tb_alu_pipe_seg.sv
// Directed self-checking bench for alu_pipe_seg (N=4, DEPTH=2, CNT_W=3).
module tb_alu_pipe_seg;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a_num;
  logic [3:0] b_num;
  logic [3:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic [3:0] flags;
  logic [2:0] op_count;
  logic [6:0] seg_result;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  alu_pipe_seg #(.N(4), .DEPTH(2), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_num      (a_num),
    .b_num      (b_num),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flags      (flags),
    .op_count   (op_count),
    .seg_result (seg_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] exp_seg(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b1000000; 4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100; 4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001; 4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010; 4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000; 4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000; 4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110; 4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110; default: g = 7'b0001110;
    endcase
`ifdef ALU_SEG_DISPLAY_EN
    return g;
`else
    return g | 7'h7F;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [3:0] a, input logic [3:0] b, input logic [3:0] o,
                          input logic [3:0] er, input logic [3:0] ef, input string nm);
    a_num = a; b_num = b; op = o; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s in_ready: got %b want 1", nm, in_ready);
    end
    step();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL %s early out_valid: got %b want 0", nm, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL %s out_valid: got %b want 1", nm, out_valid);
    end
    checks++;
    if (result !== er) begin
      errors++; $display("FAIL %s result: got %h want %h", nm, result, er);
    end
    checks++;
    if (flags !== ef) begin
      errors++; $display("FAIL %s flags: got %b want %b", nm, flags, ef);
    end
    checks++;
    if (seg_result !== exp_seg(er)) begin
      errors++; $display("FAIL %s seg: got %b want %b", nm, seg_result, exp_seg(er));
    end
    step();
    exp_cnt++;
    checks++;
    if (op_count !== 3'(exp_cnt)) begin
      errors++; $display("FAIL %s op_count: got %0d want %0d", nm, op_count, 3'(exp_cnt));
    end
  endtask

  task automatic run_stream(input int n, input bit do_stall, input string nm);
    int idx = 0;
    int rcv = 0;
    int stall_n = 0;
    logic acc, hs, stall;
    logic [3:0] er;
    for (int cyc = 0; cyc < 60 && rcv < n; cyc++) begin
      in_valid = (idx < n);
      a_num = 4'(idx + 1); b_num = 4'h0; op = 4'd7;
      stall = do_stall && out_valid && (rcv == 1) && (stall_n < 3);
      out_ready = !stall;
      #1;
      acc = in_valid && in_ready;
      hs = out_valid && out_ready;
      if (hs) begin
        er = 4'(rcv + 1);
        checks++;
        if (result !== er) begin
          errors++; $display("FAIL %s result[%0d]: got %h want %h", nm, rcv, result, er);
        end
        checks++;
        if (flags !== {er[3], er == 4'h0, 2'b00}) begin
          errors++; $display("FAIL %s flags[%0d]: got %b want %b", nm, rcv, flags, {er[3], er == 4'h0, 2'b00});
        end
        checks++;
        if (seg_result !== exp_seg(er)) begin
          errors++; $display("FAIL %s seg[%0d]: got %b want %b", nm, rcv, seg_result, exp_seg(er));
        end
        rcv++;
      end
      if (stall) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL %s stall in_ready: got %b want 0", nm, in_ready);
        end
        checks++;
        if (result !== 4'h2 || flags !== 4'b0000) begin
          errors++; $display("FAIL %s stall hold: got %h/%b want 2/0000", nm, result, flags);
        end
        checks++;
        if (seg_result !== exp_seg(4'h2)) begin
          errors++; $display("FAIL %s stall seg: got %b want %b", nm, seg_result, exp_seg(4'h2));
        end
        stall_n++;
      end
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (rcv != n) begin
      errors++; $display("FAIL %s beats received: got %0d want %0d", nm, rcv, n);
    end
    if (do_stall) begin
      checks++;
      if (stall_n != 3) begin
        errors++; $display("FAIL %s stall cycles: got %0d want 3", nm, stall_n);
      end
    end
    exp_cnt += rcv;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset handshake: got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    checks++;
    if (result !== 4'h0 || flags !== 4'h0 || op_count !== 3'd0) begin
      errors++; $display("FAIL reset regs: got %h/%b/%0d want 0/0000/0", result, flags, op_count);
    end
    checks++;
    if (seg_result !== exp_seg(4'h0)) begin
      errors++; $display("FAIL reset seg: got %b want %b", seg_result, exp_seg(4'h0));
    end
    step();
    reset = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL post-reset handshake: got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_ops();
    send_one(4'd7, 4'd9, 4'd0, 4'h0, 4'b0110, "add_7_9");
    send_one(4'd3, 4'd5, 4'd1, 4'hE, 4'b1010, "sub_3_5");
    send_one(4'd7, 4'd1, 4'd0, 4'h8, 4'b1001, "add_7_1");
    send_one(4'd9, 4'd0, 4'd3, 4'hF, 4'b1001, "div_9_0");
    send_one(4'd9, 4'd4, 4'd4, 4'h1, 4'b0000, "mod_9_4");
    send_one(4'd5, 4'd3, 4'd12, 4'h0, 4'b0101, "illegal_12");
    send_one(4'd5, 4'd3, 4'd2, 4'hF, 4'b1000, "mul_5_3");
    send_one(4'd5, 4'd4, 4'd2, 4'h4, 4'b0010, "mul_5_4");
    send_one(4'hB, 4'd1, 4'd8, 4'h6, 4'b0010, "shl_b_1");
    send_one(4'h5, 4'd1, 4'd9, 4'h2, 4'b0010, "shr_5_1");
    send_one(4'hA, 4'h5, 4'd7, 4'hF, 4'b1000, "xor_a_5");
    send_one(4'hC, 4'hA, 4'd5, 4'h8, 4'b1000, "and_c_a");
  endtask

  task automatic test_back_to_back();
    run_stream(5, 1'b1, "stream5");
    checks++;
    if (op_count !== 3'(exp_cnt)) begin
      errors++; $display("FAIL stream5 op_count: got %0d want %0d", op_count, 3'(exp_cnt));
    end
  endtask

  task automatic test_reset_mid();
    a_num = 4'd1; b_num = 4'd1; op = 4'd0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    a_num = 4'd2;
    step();
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || op_count !== 3'd0) begin
      errors++; $display("FAIL async reset: got valid=%b cnt=%0d want 0/0", out_valid, op_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL async reset in_ready: got %b want 1", in_ready);
    end
    exp_cnt = 0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL stale beat after reset: got valid=%b want 0", out_valid);
    end
    send_one(4'd4, 4'd4, 4'd0, 4'h8, 4'b1001, "post_reset_add");
  endtask

  task automatic test_wrap();
    #2;
    reset = 1'b0;
    #1;
    exp_cnt = 0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    step();
    run_stream(9, 1'b0, "wrap9");
    checks++;
    if (op_count !== 3'd1) begin
      errors++; $display("FAIL wrap op_count: got %0d want 1", op_count);
    end
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_num = '0;
    b_num = '0;
    op = '0;
    #3;
    test_reset();
    test_ops();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
